// File: rtl/cdc_src_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cdc_src_pkg
// Description : Shared helpers for the gray-pointer async FIFO source halves:
//               gray/binary conversion, pointer-width helper, stall counter
//               width.
// Revision    : 1.0 - initial release
// ============================================================================
package cdc_src_pkg;

    localparam int STALL_CNT_W = 16;

    // Pointer carries one extra wrap bit beyond the storage index.
    function automatic int ptr_w(input int log_depth);
        return log_depth + 1;
    endfunction

    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] gray);
        logic [31:0] bin;
        bin = gray;
        for (int i = 1; i < 32; i++) begin
            bin = bin ^ (gray >> i);
        end
        return bin;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cdc_gray_src_ch.sv
`default_nettype none
// ============================================================================
// Module      : cdc_gray_src_ch
// Description : Source half of one gray-pointer asynchronous FIFO, with
//               drain status and a saturating stall counter.
//   clk_i/rst_i   : clock, synchronous active-high reset
//   valid_i       : push request          ready_o : space available
//   data_i        : push payload          data_o  : flattened storage
//   wptr_o        : registered gray write pointer
//   rptr_i        : gray read pointer from destination (asynchronous)
//   drained_o     : all pushed entries consumed (per synchronised rptr)
//   clr_i         : clear stall counter   stall_cnt_o : saturating stalls
// Revision    : 1.0 - initial release
// ============================================================================
module cdc_gray_src_ch
    import cdc_src_pkg::*;
#(
    parameter int DataWidth  = 64,
    parameter int LogDepth   = 1,
    parameter int SyncStages = 2
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   valid_i,
    output logic                                   ready_o,
    input  logic [DataWidth-1:0]                   data_i,
    output logic [ptr_w(LogDepth)-1:0]             wptr_o,
    output logic [(2**LogDepth)*DataWidth-1:0]     data_o,
    input  logic [ptr_w(LogDepth)-1:0]             rptr_i,
    output logic                                   drained_o,
    input  logic                                   clr_i,
    output logic [STALL_CNT_W-1:0]                 stall_cnt_o
);

    localparam int PW    = ptr_w(LogDepth);
    localparam int DEPTH = 2 ** LogDepth;

    // Full when the read pointer is exactly one lap behind: in gray code that
    // means the top two bits differ and the rest match.
    localparam logic [PW-1:0]          C_FULL_MASK = PW'(3) << (PW - 2);
    localparam logic [STALL_CNT_W-1:0] C_STALL_MAX = '1;

    logic [PW-1:0]          r_wbin;
    logic [PW-1:0]          r_wgray;
    logic [DataWidth-1:0]   r_mem  [DEPTH];
    logic [PW-1:0]          r_sync [SyncStages];
    logic [STALL_CNT_W-1:0] r_stall;

    logic [PW-1:0]          w_rsync;
    logic [PW-1:0]          w_wbin_nxt;
    logic                   w_full;
    logic                   w_ready;
    logic                   w_push;

    assign w_rsync    = r_sync[SyncStages-1];
    assign w_wbin_nxt = r_wbin + PW'(1);
    assign w_full     = (r_wgray == (w_rsync ^ C_FULL_MASK));
    // Gating with reset keeps pushes from being accepted in the reset cycle.
    assign w_ready    = ~w_full & ~rst_i;
    assign w_push     = valid_i & w_ready;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wbin  <= '0;
            r_wgray <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_mem[k] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wbin[LogDepth-1:0]] <= data_i;
            r_wbin                      <= w_wbin_nxt;
            r_wgray                     <= PW'(bin2gray(32'(w_wbin_nxt)));
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int s = 0; s < SyncStages; s++) begin
                r_sync[s] <= '0;
            end
        end else begin
            r_sync[0] <= rptr_i;
            for (int s = 1; s < SyncStages; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            r_stall <= '0;
        end else if (valid_i && !w_ready && (r_stall != C_STALL_MAX)) begin
            r_stall <= r_stall + 1'b1;
        end
    end

    generate
        for (genvar k = 0; k < DEPTH; k++) begin : g_out
            assign data_o[k*DataWidth +: DataWidth] = r_mem[k];
        end
    endgenerate

    assign ready_o     = w_ready;
    assign wptr_o      = r_wgray;
    assign drained_o   = (r_wgray == w_rsync);
    assign stall_cnt_o = r_stall;

endmodule
`default_nettype wire

// File: rtl/cdc_gray_src_array.sv
`default_nettype none
// ============================================================================
// Module      : cdc_gray_src_array
// Description : NumCh independent gray-pointer async FIFO source halves in
//               one clock domain, driving flattened wptr/data buses.
//   clk_i/rst_i   : clock, synchronous active-high reset
//   valid_i/ready_o/clr_i/drained_o : one bit per channel
//   data_i        : channel c at [c*DataWidth +: DataWidth]
//   data_o        : entry k of channel c at [(c*D+k)*DataWidth +: DataWidth]
//   wptr_o/rptr_i : channel c at [c*(LogDepth+1) +: LogDepth+1]
//   stall_cnt_o   : channel c at [c*16 +: 16]
// Revision    : 1.0 - initial release
// ============================================================================
module cdc_gray_src_array
    import cdc_src_pkg::*;
#(
    parameter int NumCh      = 2,
    parameter int DataWidth  = 64,
    parameter int LogDepth   = 1,
    parameter int SyncStages = 2
) (
    input  logic                                       clk_i,
    input  logic                                       rst_i,
    input  logic [NumCh-1:0]                           valid_i,
    output logic [NumCh-1:0]                           ready_o,
    input  logic [NumCh*DataWidth-1:0]                 data_i,
    output logic [NumCh*ptr_w(LogDepth)-1:0]           wptr_o,
    output logic [NumCh*(2**LogDepth)*DataWidth-1:0]   data_o,
    input  logic [NumCh*ptr_w(LogDepth)-1:0]           rptr_i,
    output logic [NumCh-1:0]                           drained_o,
    input  logic [NumCh-1:0]                           clr_i,
    output logic [NumCh*STALL_CNT_W-1:0]               stall_cnt_o
);

    localparam int PW  = ptr_w(LogDepth);
    localparam int DBW = (2 ** LogDepth) * DataWidth;

    generate
        for (genvar c = 0; c < NumCh; c++) begin : g_ch
            cdc_gray_src_ch #(
                .DataWidth  (DataWidth),
                .LogDepth   (LogDepth),
                .SyncStages (SyncStages)
            ) u_ch (
                .clk_i       (clk_i),
                .rst_i       (rst_i),
                .valid_i     (valid_i[c]),
                .ready_o     (ready_o[c]),
                .data_i      (data_i[c*DataWidth +: DataWidth]),
                .wptr_o      (wptr_o[c*PW +: PW]),
                .data_o      (data_o[c*DBW +: DBW]),
                .rptr_i      (rptr_i[c*PW +: PW]),
                .drained_o   (drained_o[c]),
                .clr_i       (clr_i[c]),
                .stall_cnt_o (stall_cnt_o[c*STALL_CNT_W +: STALL_CNT_W])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_cdc_gray_src_array.sv
`default_nettype none
// ============================================================================
// Module      : tb_cdc_gray_src_array
// Description : Directed self-checking bench for cdc_gray_src_array
//               (2 channels, 8-bit data, depth 2, 2 sync stages).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cdc_gray_src_array;

    localparam int NCH = 2;
    localparam int DW  = 8;
    localparam int LD  = 1;
    localparam int SS  = 2;
    localparam int PW  = LD + 1;
    localparam int D   = 2 ** LD;

    logic                   clk_i = 1'b0;
    logic                   rst_i;
    logic [NCH-1:0]         valid_i;
    logic [NCH-1:0]         ready_o;
    logic [NCH*DW-1:0]      data_i;
    logic [NCH*PW-1:0]      wptr_o;
    logic [NCH*D*DW-1:0]    data_o;
    logic [NCH*PW-1:0]      rptr_i;
    logic [NCH-1:0]         drained_o;
    logic [NCH-1:0]         clr_i;
    logic [NCH*16-1:0]      stall_cnt_o;

    int n_checks = 0;
    int n_errors = 0;

    cdc_gray_src_array #(
        .NumCh      (NCH),
        .DataWidth  (DW),
        .LogDepth   (LD),
        .SyncStages (SS)
    ) u_dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .data_i      (data_i),
        .wptr_o      (wptr_o),
        .data_o      (data_o),
        .rptr_i      (rptr_i),
        .drained_o   (drained_o),
        .clr_i       (clr_i),
        .stall_cnt_o (stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge and settle before sampling.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [DW-1:0] entry(input int c, input int k);
        return data_o[(c*D+k)*DW +: DW];
    endfunction

    function automatic logic [PW-1:0] wptr(input int c);
        return wptr_o[c*PW +: PW];
    endfunction

    function automatic logic [15:0] stall(input int c);
        return stall_cnt_o[c*16 +: 16];
    endfunction

    logic [PW-1:0] wrap_gray [8];

    initial begin
        // Write counter sits at 2 (gray 11) when the wrap test begins.
        wrap_gray = '{2'b10, 2'b00, 2'b01, 2'b11, 2'b10, 2'b00, 2'b01, 2'b11};

        rst_i   = 1'b1;
        valid_i = '1;
        data_i  = '0;
        rptr_i  = '0;
        clr_i   = '0;

        // Reset held 3 cycles with valid asserted.
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_ready", 32'(ready_o), 32'h0);
            check("rst_wptr", 32'(wptr_o), 32'h0);
            check("rst_stall", 32'(stall_cnt_o), 32'h0);
        end
        rst_i   = 1'b0;
        valid_i = '0;
        #1;
        check("post_rst_ready", 32'(ready_o), 32'h3);
        check("post_rst_drained", 32'(drained_o), 32'h3);
        check("post_rst_data", 32'(data_o), 32'h0);

        // Fill channel 0.
        valid_i[0]  = 1'b1;
        data_i[7:0] = 8'h0A;
        step();
        check("fill1_wptr", 32'(wptr(0)), 32'h1);
        check("fill1_e0", 32'(entry(0, 0)), 32'h0A);
        check("fill1_ready", 32'(ready_o[0]), 32'h1);
        data_i[7:0] = 8'h0B;
        step();
        valid_i[0] = 1'b0;
        check("fill2_wptr", 32'(wptr(0)), 32'h3);
        check("fill2_e1", 32'(entry(0, 1)), 32'h0B);
        check("fill2_e0", 32'(entry(0, 0)), 32'h0A);
        check("fill2_ready", 32'(ready_o[0]), 32'h0);
        check("fill2_drained", 32'(drained_o[0]), 32'h0);

        // Drain: ready returns after exactly two edges.
        rptr_i[1:0] = 2'b01;
        step();
        check("drain_ready_1", 32'(ready_o[0]), 32'h0);
        step();
        check("drain_ready_2", 32'(ready_o[0]), 32'h1);
        check("drain_drained_mid", 32'(drained_o[0]), 32'h0);
        rptr_i[1:0] = 2'b11;
        step();
        check("drain_drained_1", 32'(drained_o[0]), 32'h0);
        step();
        check("drain_drained_2", 32'(drained_o[0]), 32'h1);

        // Wrap-around: 8 pushes, consumer catches up after each.
        for (int i = 0; i < 8; i++) begin
            check($sformatf("wrap%0d_ready", i), 32'(ready_o[0]), 32'h1);
            valid_i[0]  = 1'b1;
            data_i[7:0] = 8'(8'h10 + i);
            step();
            valid_i[0] = 1'b0;
            check($sformatf("wrap%0d_wptr", i), 32'(wptr(0)), 32'(wrap_gray[i]));
            check($sformatf("wrap%0d_entry", i), 32'(entry(0, i % 2)), 32'(8'h10 + i));
            rptr_i[1:0] = wrap_gray[i];
            step();
            step();
        end
        check("wrap_drained", 32'(drained_o[0]), 32'h1);

        // Stall counter and channel independence.
        valid_i      = 2'b11;
        data_i[7:0]  = 8'hC1;
        data_i[15:8] = 8'h5A;
        step();
        valid_i[1]  = 1'b0;
        data_i[7:0] = 8'hC2;
        check("ch1_wptr", 32'(wptr(1)), 32'h1);
        check("ch1_entry", 32'(entry(1, 0)), 32'h5A);
        step();
        check("stall_full_ready", 32'(ready_o[0]), 32'h0);
        check("stall_start", 32'(stall(0)), 32'h0);
        for (int i = 0; i < 10; i++) step();
        check("stall_10", 32'(stall(0)), 32'd10);
        for (int i = 0; i < 65600; i++) step();
        check("stall_sat", 32'(stall(0)), 32'hFFFF);
        clr_i[0] = 1'b1;
        step();
        clr_i[0] = 1'b0;
        check("stall_clr", 32'(stall(0)), 32'h0);
        step();
        check("stall_after_clr", 32'(stall(0)), 32'h1);
        check("ch1_stall", 32'(stall(1)), 32'h0);
        check("ch1_wptr_hold", 32'(wptr(1)), 32'h1);
        check("ch0_entry_kept", 32'(entry(0, 1)), 32'hC2);
        valid_i = '0;

        // Reset mid-fill.
        rst_i  = 1'b1;
        rptr_i = '0;
        step();
        rst_i = 1'b0;
        check("rst2_wptr", 32'(wptr_o), 32'h0);
        valid_i[0]  = 1'b1;
        data_i[7:0] = 8'h77;
        step();
        check("mid_wptr", 32'(wptr(0)), 32'h1);
        check("mid_entry", 32'(entry(0, 0)), 32'h77);
        rst_i       = 1'b1;
        data_i[7:0] = 8'h88;
        #1;
        check("mid_rst_ready", 32'(ready_o), 32'h0);
        step();
        rst_i   = 1'b0;
        valid_i = '0;
        #1;
        check("mid_rst_wptr", 32'(wptr_o), 32'h0);
        check("mid_rst_data", 32'(data_o), 32'h0);
        check("mid_rst_ready_after", 32'(ready_o), 32'h3);
        check("mid_rst_drained", 32'(drained_o), 32'h3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
